// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Measures an asynchronous PWM line in clk cycles. For every complete PWM
// cycle it reports the high time and the rise-to-rise period, with a
// one-cycle strobe. It raises a loss-of-signal flag when no edge arrives
// before the period counter saturates.
//
// Parameters:
//   CNT_W      width of the source PWM counter; measurements are CNT_W+1 bits
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   pwm_in     asynchronous PWM input (synchronized here)
//   high_time  high cycles of the last complete period
//   period     cycles between the last two rise events
//   meas_vld   one-cycle strobe: high_time/period updated this cycle
//   no_sig     level: no valid measurement since reset or last timeout
//
// Build option:
//   PWM_CAP_FILTER_EN  when defined, a 3-sample glitch filter follows the
//                      synchronizer. It rejects 1-2 cycle pulses and adds
//                      2 cycles of latency to every edge.
// ---------------------------------------------------------------------------
module pwm_capture #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W:0]   high_time,
    output logic [CNT_W:0]   period,
    output logic             meas_vld,
    output logic             no_sig
);

    localparam int MEAS_W = CNT_W + 1;
    localparam logic [MEAS_W-1:0] SAT = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v);
        return (v == SAT) ? v : v + 1'b1;
    endfunction

    logic              sync_p0;
    logic              sync_p1;
    logic              lvl;
    logic              lvl_prev;
    logic              rise;
    logic              fall;
    logic [1:0]        state;
    logic [MEAS_W-1:0] per_cnt;
    logic [MEAS_W-1:0] hi_cnt;
    logic [MEAS_W-1:0] hi_lat;
    logic              per_sat;

    // Stage p0/p1: two-flop synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= pwm_in;
            sync_p1 <= sync_p0;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    // Stage p2/p3: glitch filter. The level follows the synchronized input
    // only once three consecutive samples agree. Taking the third sample
    // combinationally keeps the added delay at exactly 2 cycles.
    logic hist_p2;
    logic hist_p3;
    logic filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_p2 <= 1'b0;
            hist_p3 <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist_p2 <= sync_p1;
            hist_p3 <= hist_p2;
            filt_q  <= lvl;
        end
    end

    assign lvl = ((sync_p1 == hist_p2) && (hist_p2 == hist_p3)) ? sync_p1 : filt_q;
`else
    assign lvl = sync_p1;
`endif

    // Edge detection against the previous level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_prev <= 1'b0;
        end else begin
            lvl_prev <= lvl;
        end
    end

    assign rise    = lvl & ~lvl_prev;
    assign fall    = ~lvl & lvl_prev;
    assign per_sat = (per_cnt == SAT);

    // Counters: a rise restarts both. The high counter only runs while in HIGH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= MEAS_W'(1);
            hi_cnt  <= MEAS_W'(1);
        end else begin
            per_cnt <= sat_inc(per_cnt);
            if (state == HIGH) begin
                hi_cnt <= sat_inc(hi_cnt);
            end
        end
    end

    // Measurement FSM and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hi_lat    <= '0;
            high_time <= '0;
            period    <= '0;
            meas_vld  <= 1'b0;
            no_sig    <= 1'b1;
        end else begin
            meas_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The period started here has no known start; never reported.
                    if (rise) begin
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hi_lat <= hi_cnt;
                        state  <= LOW;
                    end else if (per_sat) begin
                        state  <= IDLE;
                        no_sig <= 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                        if (per_sat) begin
                            // Overlong period: treat as timeout plus a fresh start.
                            no_sig <= 1'b1;
                        end else begin
                            period    <= per_cnt;
                            high_time <= hi_lat;
                            meas_vld  <= 1'b1;
                            no_sig    <= 1'b0;
                        end
                    end else if (per_sat) begin
                        state  <= IDLE;
                        no_sig <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//
// Directed bench for pwm_capture. It drives PWM waveforms on the falling
// clock edge. A monitor, also on the falling edge, logs every strobe with
// its values and checks the strobe latency and spacing. The main sequence
// compares the logged measurements and flags against hand-computed values.
// It is built with or without PWM_CAP_FILTER_EN.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int CNT_W = 8;
`ifdef PWM_CAP_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pwm_in;
    logic [CNT_W:0] high_time;
    logic [CNT_W:0] period;
    logic           meas_vld;
    logic           no_sig;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .high_time (high_time),
        .period    (period),
        .meas_vld  (meas_vld),
        .no_sig    (no_sig)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   rise_cyc = 0;
    int   strobes = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ht_q[$];
    int   per_q[$];
    logic vld_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_meas(input string tag, input int ht, input int per);
        chk({tag, "_avail"}, 32'(ht_q.size() > 0), 1);
        if (ht_q.size() > 0) begin
            chk({tag, "_high"}, ht_q.pop_front(), ht);
            chk({tag, "_per"}, per_q.pop_front(), per);
        end
    endtask

    // Drive level v on the falling edge and hold it for n cycles.
    task automatic drive(input logic v, input int n);
        @(negedge clk);
        if (v && !pwm_in) rise_cyc = cyc;
        pwm_in = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Strobe monitor
    always @(negedge clk) begin
        if (meas_vld === 1'b1) begin
            strobes++;
            chk("strobe_latency", cyc - rise_cyc, LAT);
            chk("strobe_gap", 32'(vld_d), 0);
            chk("no_sig_at_strobe", 32'(no_sig), 0);
            ht_q.push_back(int'(high_time));
            per_q.push_back(int'(period));
        end
        vld_d <= meas_vld;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int r;
        rst_n  = 1'b0;
        pwm_in = 1'b0;

        // Reset held while the line toggles
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pwm_in = ~pwm_in;
        end
        @(negedge clk);
        pwm_in = 1'b0;
        chk("rst_no_sig", 32'(no_sig), 1);
        chk("rst_vld", 32'(meas_vld), 0);
        chk("rst_high", 32'(high_time), 0);
        chk("rst_per", 32'(period), 0);
        chk("rst_strobes", strobes, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Steady 141/115 PWM; the first period is never reported
        drive(1'b1, 141); drive(1'b0, 115);
        chk("first_rise_silent", strobes, 0);
        chk("no_sig_before_first", 32'(no_sig), 1);
        repeat (3) begin drive(1'b1, 141); drive(1'b0, 115); end
        chk("steady_no_sig", 32'(no_sig), 0);
        chk("steady_high_out", 32'(high_time), 141);
        chk("steady_per_out", 32'(period), 256);

        // Duty change to 20/236
        repeat (3) begin drive(1'b1, 20); drive(1'b0, 236); end
        chk("stream_strobes", strobes, 6);
        for (int i = 0; i < 4; i++) expect_meas("steady", 141, 256);
        expect_meas("duty_a", 20, 256);
        expect_meas("duty_b", 20, 256);

        // Stuck low after the last rise
        r = rise_cyc;
        wait_cyc(r + 508);
        chk("stucklo_early", 32'(no_sig), 0);
        wait_cyc(r + 520);
        chk("stucklo_flag", 32'(no_sig), 1);
        chk("stucklo_high_hold", 32'(high_time), 20);
        chk("stucklo_per_hold", 32'(period), 256);

        // Restart: two rises give one strobe
        s0 = strobes;
        drive(1'b1, 141); drive(1'b0, 115);
        drive(1'b1, 30);  drive(1'b0, 70);
        chk("restart_strobes", strobes - s0, 1);
        expect_meas("restart", 141, 256);

        // Stuck high
        drive(1'b1, 1);
        r = rise_cyc;
        wait_cyc(r + 508);
        chk("stuckhi_early", 32'(no_sig), 0);
        chk("stuckhi_strobes", strobes - s0, 2);
        expect_meas("stuckhi_last", 30, 100);
        wait_cyc(r + 520);
        chk("stuckhi_flag", 32'(no_sig), 1);
        chk("stuckhi_high_hold", 32'(high_time), 30);
        chk("stuckhi_per_hold", 32'(period), 100);

        // Recovery from IDLE while the line is high
        s0 = strobes;
        drive(1'b0, 50); drive(1'b1, 50); drive(1'b0, 50); drive(1'b1, 60);
        chk("recover_strobes", strobes - s0, 1);
        expect_meas("recover", 50, 100);
        chk("recover_no_sig", 32'(no_sig), 0);

        // Reset in the middle of a high phase
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_no_sig", 32'(no_sig), 1);
        chk("midrst_vld", 32'(meas_vld), 0);
        chk("midrst_high", 32'(high_time), 0);
        chk("midrst_per", 32'(period), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        s0 = strobes;
        repeat (60) @(negedge clk);
        drive(1'b0, 100);
        chk("midrst_no_strobe", strobes - s0, 0);
        chk("midrst_no_sig_after", 32'(no_sig), 1);

        // Glitch: 2-cycle low inside a 141-cycle high
        drive(1'b1, 141);
        ht_q.delete();
        per_q.delete();
        s0 = strobes;
        drive(1'b0, 115);
        drive(1'b1, 60); drive(1'b0, 2); drive(1'b1, 79); drive(1'b0, 115);
        drive(1'b1, 141); drive(1'b0, 10);
        expect_meas("glitch_prev", 141, 256);
`ifdef PWM_CAP_FILTER_EN
        chk("glitch_strobes", strobes - s0, 2);
        expect_meas("glitch_rej", 141, 256);
`else
        chk("glitch_strobes", strobes - s0, 3);
        expect_meas("glitch_split_a", 60, 62);
        expect_meas("glitch_split_b", 79, 194);
`endif
        chk("leftover_strobes", ht_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
